// File: rtl/eq_pkg.sv
// eq_pkg: shared types and widths for the stereo sample queue
package eq_pkg;
  localparam int SMPL_W = 16;
  typedef enum logic {Q_IDLE, Q_READ} queue_state_t;
  typedef struct packed {
    logic [SMPL_W-1:0] lft;
    logic [SMPL_W-1:0] rght;
  } stereo_smpl_t;
endpackage

// File: rtl/dualport_ram_stereo.sv
// dualport_ram_stereo: DEPTH x stereo-pair RAM, one write port, one registered read port
module dualport_ram_stereo
  import eq_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [PW-1:0]       waddr,
  input  logic [2*SMPL_W-1:0] wdata,
  input  logic [PW-1:0]       raddr,
  output logic [2*SMPL_W-1:0] rdata
);
  logic [2*SMPL_W-1:0] mem [DEPTH];
  // array write and synchronous read; contents are undefined until written
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/lf_sample_queue.sv
// lf_sample_queue: circular stereo queue replaying the N_TAPS newest pairs after each sample
module lf_sample_queue
  import eq_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int N_TAPS = 1021
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt_smpl,
  input  logic [SMPL_W-1:0] lft_smpl,
  input  logic [SMPL_W-1:0] rght_smpl,
  output logic              sequencing,
  output logic [SMPL_W-1:0] lft_out,
  output logic [SMPL_W-1:0] rght_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(N_TAPS + 1);
  localparam logic [FW-1:0] TAPS_F = FW'(N_TAPS);
  localparam logic [PW-1:0] TAPS_P = PW'(N_TAPS);
  queue_state_t      state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, raddr;
  logic [FW-1:0]     fill_q, fill_d, cnt_q, cnt_d;
  logic              pending_q, pending_d, seq_q, seq_d;
  logic [SMPL_W-1:0] lft_q, lft_d, rght_q, rght_d;
  logic              start, win_end, load;
  stereo_smpl_t      rd_smpl;
  dualport_ram_stereo #(.DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .we   (wrt_smpl),
    .waddr(wr_ptr_q),
    .wdata({lft_smpl, rght_smpl}),
    .raddr(raddr),
    .rdata(rd_smpl)
  );
  // next-state: the first read address is issued on the start edge so c=1 already shows the oldest pair
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(wrt_smpl);
    fill_d    = (wrt_smpl && fill_q != TAPS_F) ? fill_q + FW'(1) : fill_q;
    win_end   = state_q == Q_READ && cnt_q == TAPS_F;
    start     = state_q == Q_IDLE && (pending_q || (wrt_smpl && fill_d == TAPS_F));
    raddr     = start ? wr_ptr_d - TAPS_P : rd_ptr_q;
    rd_ptr_d  = raddr + PW'(1);
    load      = state_q == Q_READ && cnt_q != TAPS_F;
    pending_d = start ? 1'b0 : (state_q == Q_READ && wrt_smpl) ? 1'b1 : pending_q;
    cnt_d     = start ? '0 : state_q == Q_READ ? cnt_q + FW'(1) : cnt_q;
    state_d   = start ? Q_READ : win_end ? Q_IDLE : state_q;
    seq_d     = state_d == Q_READ;
    lft_d     = load ? rd_smpl.lft : lft_q;
    rght_d    = load ? rd_smpl.rght : rght_q;
  end
  // FSM, pointers, counters and registered outputs; reset aborts a window at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= Q_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      seq_q     <= 1'b0;
      lft_q     <= '0;
      rght_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      seq_q     <= seq_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
    end
  end
  assign sequencing = seq_q;
  assign lft_out    = lft_q;
  assign rght_out   = rght_q;
endmodule
